// File: rtl/axi_ar_split_buffer.sv
// AXI4 AR-channel buffer: in-order FIFO whose head INCR bursts are re-issued as sub-bursts of <= MAX_SPLIT_LEN beats.
// Optional define AXI_AR_SPLIT_BUFFER_LEVEL_EN adds level_o (registered FIFO occupancy).
module axi_ar_split_buffer #(
   parameter int ID_WIDTH      = 4,
   parameter int ADDR_WIDTH    = 32,
   parameter int USER_WIDTH    = 6,
   parameter int BUFFER_DEPTH  = 4,
   parameter int MAX_SPLIT_LEN = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  slave_valid_i,
   output logic                  slave_ready_o,
   input  logic [ADDR_WIDTH-1:0] slave_addr_i,
   input  logic [7:0]            slave_len_i,
   input  logic [2:0]            slave_size_i,
   input  logic [1:0]            slave_burst_i,
   input  logic [2:0]            slave_prot_i,
   input  logic [3:0]            slave_region_i,
   input  logic                  slave_lock_i,
   input  logic [3:0]            slave_cache_i,
   input  logic [3:0]            slave_qos_i,
   input  logic [ID_WIDTH-1:0]   slave_id_i,
   input  logic [USER_WIDTH-1:0] slave_user_i,
   output logic                  master_valid_o,
   input  logic                  master_ready_i,
   output logic [ADDR_WIDTH-1:0] master_addr_o,
   output logic [7:0]            master_len_o,
   output logic [2:0]            master_size_o,
   output logic [1:0]            master_burst_o,
   output logic [2:0]            master_prot_o,
   output logic [3:0]            master_region_o,
   output logic                  master_lock_o,
   output logic [3:0]            master_cache_o,
   output logic [3:0]            master_qos_o,
   output logic [ID_WIDTH-1:0]   master_id_o,
   output logic [USER_WIDTH-1:0] master_user_o,
   output logic                  master_last_o
`ifdef AXI_AR_SPLIT_BUFFER_LEVEL_EN
   ,
   output logic [$clog2(BUFFER_DEPTH+1)-1:0] level_o
`endif
);

   localparam int CNT_W = $clog2(BUFFER_DEPTH + 1);
   localparam int PTR_W = (BUFFER_DEPTH > 1) ? $clog2(BUFFER_DEPTH) : 1;
   localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(BUFFER_DEPTH);
   localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(BUFFER_DEPTH - 1);
   localparam logic [8:0]       MAX_BEATS = 9'(MAX_SPLIT_LEN);
   localparam logic [7:0]       MAX_LEN   = 8'(MAX_SPLIT_LEN - 1);
   localparam logic [1:0]       BURST_INCR = 2'b01;

   typedef struct packed {
      logic [ADDR_WIDTH-1:0] addr;
      logic [7:0]            len;
      logic [2:0]            size;
      logic [1:0]            burst;
      logic [2:0]            prot;
      logic [3:0]            region;
      logic                  lock;
      logic [3:0]            cache;
      logic [3:0]            qos;
      logic [ID_WIDTH-1:0]   id;
      logic [USER_WIDTH-1:0] user;
   } ar_t;

   typedef enum logic {IDLE, SPLIT} state_t;

   ar_t                   mem_q [BUFFER_DEPTH];
   ar_t                   slave_ar;
   ar_t                   head;
   logic [CNT_W-1:0]      count_q;
   logic [PTR_W-1:0]      rd_ptr_q, wr_ptr_q;
   state_t                state_q, state_d;
   logic [8:0]            rem_q, rem_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                  fifo_valid, push, pop, handshake;
   logic [8:0]            head_beats;
   logic                  head_split;
   logic [ADDR_WIDTH-1:0] step, head_aligned;

   assign slave_ar = '{addr: slave_addr_i, len: slave_len_i, size: slave_size_i,
                       burst: slave_burst_i, prot: slave_prot_i, region: slave_region_i,
                       lock: slave_lock_i, cache: slave_cache_i, qos: slave_qos_i,
                       id: slave_id_i, user: slave_user_i};

   // Gated by rst_ni so no request is "accepted" while reset is discarding it.
   assign slave_ready_o = rst_ni & (count_q < DEPTH_C);
   assign push          = slave_valid_i & slave_ready_o;
   assign fifo_valid    = (count_q != '0);
   assign head          = mem_q[rd_ptr_q];

   assign head_beats   = {1'b0, head.len} + 9'd1;
   assign head_split   = (head.burst == BURST_INCR) && !head.lock && (head_beats > MAX_BEATS);
   assign step         = ADDR_WIDTH'(MAX_SPLIT_LEN) << head.size;
   assign head_aligned = head.addr & ({ADDR_WIDTH{1'b1}} << head.size);

   // NOTE: payload storage has no reset; count_q alone says which entries are meaningful.
   always_ff @(posedge clk_i) begin
      if (push) mem_q[wr_ptr_q] <= slave_ar;
   end

   // NOTE: non-blocking assignments here so every register samples pre-edge values.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         count_q  <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         state_q  <= IDLE;
         rem_q    <= '0;
         addr_q   <= '0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         addr_q  <= addr_d;
         if (push) wr_ptr_q <= (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_q <= (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
         case ({push, pop})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_d         = state_q;
      rem_d           = rem_q;
      addr_d          = addr_q;
      pop             = 1'b0;
      master_valid_o  = fifo_valid;
      master_addr_o   = head.addr;
      master_len_o    = head.len;
      master_size_o   = head.size;
      master_burst_o  = head.burst;
      master_prot_o   = head.prot;
      master_region_o = head.region;
      master_lock_o   = head.lock;
      master_cache_o  = head.cache;
      master_qos_o    = head.qos;
      master_id_o     = head.id;
      master_user_o   = head.user;
      master_last_o   = 1'b0;
      handshake       = fifo_valid & master_ready_i;

      case (state_q)
         IDLE: begin
            if (head_split) begin
               master_len_o = MAX_LEN;
               if (handshake) begin
                  rem_d   = head_beats - MAX_BEATS;
                  addr_d  = head_aligned + step;
                  state_d = SPLIT;
               end
            end else begin
               master_last_o = fifo_valid;
               pop           = handshake;
            end
         end
         SPLIT: begin
            master_addr_o = addr_q;
            master_len_o  = (rem_q > MAX_BEATS) ? MAX_LEN : 8'(rem_q - 9'd1);
            master_last_o = (rem_q <= MAX_BEATS);
            if (handshake) begin
               if (master_last_o) begin
                  pop     = 1'b1;
                  state_d = IDLE;
               end else begin
                  rem_d  = rem_q - MAX_BEATS;
                  addr_d = addr_q + step;
               end
            end
         end
      endcase
   end

`ifdef AXI_AR_SPLIT_BUFFER_LEVEL_EN
   assign level_o = count_q;
`endif

endmodule

// File: tb/tb_axi_ar_split_buffer.sv
// Self-checking bench for axi_ar_split_buffer: directed vector table, stall/order, mid-split reset
// and randomized traffic scored against a queue-based burst-splitting model.
module tb_axi_ar_split_buffer;

   localparam int IDW = 4, AW = 32, UW = 6, DEPTH = 4, MAXL = 16;
   localparam logic [1:0] FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10;

   logic clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   logic rst_ni = 1'b0;
   logic slave_valid_i = 1'b0, slave_ready_o;
   logic [AW-1:0] slave_addr_i = '0;
   logic [7:0] slave_len_i = '0;
   logic [2:0] slave_size_i = '0, slave_prot_i = '0;
   logic [1:0] slave_burst_i = '0;
   logic [3:0] slave_region_i = '0, slave_cache_i = '0, slave_qos_i = '0;
   logic slave_lock_i = 1'b0;
   logic [IDW-1:0] slave_id_i = '0;
   logic [UW-1:0] slave_user_i = '0;
   logic master_valid_o, master_ready_i = 1'b0, master_last_o, master_lock_o;
   logic [AW-1:0] master_addr_o;
   logic [7:0] master_len_o;
   logic [2:0] master_size_o, master_prot_o;
   logic [1:0] master_burst_o;
   logic [3:0] master_region_o, master_cache_o, master_qos_o;
   logic [IDW-1:0] master_id_o;
   logic [UW-1:0] master_user_o;
`ifdef AXI_AR_SPLIT_BUFFER_LEVEL_EN
   logic [$clog2(DEPTH+1)-1:0] level_o;
`endif

   axi_ar_split_buffer #(.ID_WIDTH(IDW), .ADDR_WIDTH(AW), .USER_WIDTH(UW),
                         .BUFFER_DEPTH(DEPTH), .MAX_SPLIT_LEN(MAXL)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .slave_valid_i(slave_valid_i), .slave_ready_o(slave_ready_o),
      .slave_addr_i(slave_addr_i), .slave_len_i(slave_len_i), .slave_size_i(slave_size_i),
      .slave_burst_i(slave_burst_i), .slave_prot_i(slave_prot_i), .slave_region_i(slave_region_i),
      .slave_lock_i(slave_lock_i), .slave_cache_i(slave_cache_i), .slave_qos_i(slave_qos_i),
      .slave_id_i(slave_id_i), .slave_user_i(slave_user_i),
      .master_valid_o(master_valid_o), .master_ready_i(master_ready_i),
      .master_addr_o(master_addr_o), .master_len_o(master_len_o), .master_size_o(master_size_o),
      .master_burst_o(master_burst_o), .master_prot_o(master_prot_o),
      .master_region_o(master_region_o), .master_lock_o(master_lock_o),
      .master_cache_o(master_cache_o), .master_qos_o(master_qos_o),
      .master_id_o(master_id_o), .master_user_o(master_user_o), .master_last_o(master_last_o)
`ifdef AXI_AR_SPLIT_BUFFER_LEVEL_EN
      , .level_o(level_o)
`endif
   );

   typedef struct packed {
      logic [AW-1:0] addr; logic [7:0] len; logic [2:0] size; logic [1:0] burst; logic lock;
      logic [2:0] prot; logic [3:0] region; logic [3:0] cache; logic [3:0] qos;
      logic [IDW-1:0] id; logic [UW-1:0] user;
   } req_t;

   typedef struct packed { logic [AW-1:0] addr; logic [7:0] len; logic last; logic [30:0] attr; } exp_t;

   typedef struct { req_t r; int n; logic [AW-1:0] ea [4]; logic [7:0] el [4]; } vec_t;

   exp_t           exp_q [$];
   logic [IDW-1:0] hs_ids [$];
   int             checks = 0, errors = 0;
   bit             mon_en = 1'b0;
   wire [30:0] attr_o = {master_id_o, master_size_o, master_burst_o, master_lock_o, master_prot_o,
                         master_region_o, master_cache_o, master_qos_o, master_user_o};

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp_v);
      end
   endtask

   function automatic logic [30:0] attr_of(input req_t r);
      return {r.id, r.size, r.burst, r.lock, r.prot, r.region, r.cache, r.qos, r.user};
   endfunction

   function automatic req_t mkreq(input logic [AW-1:0] a, input logic [7:0] l, input logic [2:0] s,
                                  input logic [1:0] b, input logic lk, input logic [IDW-1:0] id);
      req_t r;
      r = '{addr: a, len: l, size: s, burst: b, lock: lk, prot: 3'h2, region: 4'h1,
            cache: 4'h3, qos: 4'h5, id: id, user: UW'(id) + 6'd7};
      return r;
   endfunction

   // Reference: an original request covers len+1 beats; sub-burst k starts k*MAX beats past
   // the size-aligned start (the first keeps the original address).
   function automatic void expand(input req_t r);
      int beats = int'(r.len) + 1;
      bit split = (r.burst == INCR) && !r.lock && (beats > MAXL);
      logic [AW-1:0] al = (r.addr >> r.size) << r.size;
      if (!split) begin
         exp_q.push_back('{addr: r.addr, len: r.len, last: 1'b1, attr: attr_of(r)});
         return;
      end
      for (int k = 0; k * MAXL < beats; k++) begin
         int chunk = (beats - k * MAXL < MAXL) ? beats - k * MAXL : MAXL;
         logic [AW-1:0] a = (k == 0) ? r.addr : al + (AW'(k * MAXL) << r.size);
         exp_q.push_back('{addr: a, len: 8'(chunk - 1), last: ((k + 1) * MAXL >= beats), attr: attr_of(r)});
      end
   endfunction

   task automatic send(input req_t r);
      {slave_addr_i, slave_len_i, slave_size_i, slave_burst_i, slave_lock_i, slave_prot_i,
       slave_region_i, slave_cache_i, slave_qos_i, slave_id_i, slave_user_i} = r;
      slave_valid_i = 1'b1;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk_i);
         if (slave_ready_o) begin
            expand(r);
            @(posedge clk_i); #1;
            slave_valid_i = 1'b0;
            return;
         end
      end
      check("send_timeout", 0, 1);
      slave_valid_i = 1'b0;
   endtask

   task automatic wait_drain(input int budget);
      for (int i = 0; i < budget; i++) begin
         @(negedge clk_i);
         if (exp_q.size() == 0 && !master_valid_o) break;
      end
      check("drain_pending", exp_q.size(), 0);
      check("drain_valid", master_valid_o, 0);
      @(posedge clk_i); #1;
   endtask

   // Scoreboard and hold-stability monitor on the master side.
   initial begin : monitor
      logic [71:0] prev, cur;
      bit stalled;
      exp_t e;
      stalled = 1'b0;
      forever begin
         @(negedge clk_i);
         if (!mon_en) begin stalled = 1'b0; continue; end
         cur = {master_addr_o, master_len_o, master_last_o, attr_o};
         if (stalled) check("stable_while_stalled", cur, prev);
         if (master_valid_o && master_ready_i) begin
            if (exp_q.size() == 0) check("unexpected_ar", 1, 0);
            else begin
               e = exp_q.pop_front();
               check("ar_addr", master_addr_o, e.addr);
               check("ar_len", master_len_o, e.len);
               check("ar_last", master_last_o, e.last);
               check("ar_attr", attr_o, e.attr);
               hs_ids.push_back(master_id_o);
            end
         end
         prev = cur;
         stalled = master_valid_o && !master_ready_i;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   vec_t vec [9];
   bit   rnd_done;

   initial begin
      vec[0] = '{mkreq(32'h1000, 7, 2, INCR, 0, 1), 1, '{32'h1000, 0, 0, 0}, '{7, 0, 0, 0}};
      vec[1] = '{mkreq(32'h2000, 63, 3, INCR, 0, 2), 4,
                 '{32'h2000, 32'h2080, 32'h2100, 32'h2180}, '{15, 15, 15, 15}};
      vec[2] = '{mkreq(32'h3004, 40, 3, INCR, 0, 3), 3, '{32'h3004, 32'h3080, 32'h3100, 0}, '{15, 15, 8, 0}};
      vec[3] = '{mkreq(32'h4000, 15, 2, WRAP, 0, 4), 1, '{32'h4000, 0, 0, 0}, '{15, 0, 0, 0}};
      vec[4] = '{mkreq(32'h5000, 31, 2, INCR, 1, 5), 1, '{32'h5000, 0, 0, 0}, '{31, 0, 0, 0}};
      vec[5] = '{mkreq(32'h6000, 200, 1, FIXED, 0, 6), 1, '{32'h6000, 0, 0, 0}, '{200, 0, 0, 0}};
      vec[6] = '{mkreq(32'h7001, 16, 0, INCR, 0, 7), 2, '{32'h7001, 32'h7011, 0, 0}, '{15, 0, 0, 0}};
      vec[7] = '{mkreq(32'h8000, 15, 2, INCR, 0, 8), 1, '{32'h8000, 0, 0, 0}, '{15, 0, 0, 0}};
      vec[8] = '{mkreq(32'hFFFF_FF80, 31, 3, INCR, 0, 9), 2, '{32'hFFFF_FF80, 32'h0, 0, 0}, '{15, 15, 0, 0}};

      // Reset state.
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      check("rst_master_valid", master_valid_o, 0);
      check("rst_slave_ready", slave_ready_o, 0);
      check("rst_master_last", master_last_o, 0);
`ifdef AXI_AR_SPLIT_BUFFER_LEVEL_EN
      check("rst_level", level_o, 0);
`endif
      @(posedge clk_i); #1;
      rst_ni = 1'b1;
      @(negedge clk_i);
      check("ready_after_release", slave_ready_o, 1);
      @(posedge clk_i); #1;
      mon_en = 1'b1;
      master_ready_i = 1'b1;

      // Directed vectors with exact cycle-by-cycle expectations.
      for (int v = 0; v < 9; v++) begin
         send(vec[v].r);
         for (int j = 0; j < vec[v].n; j++) begin
            @(negedge clk_i);
            check($sformatf("v%0d_valid%0d", v, j), master_valid_o, 1);
            check($sformatf("v%0d_addr%0d", v, j), master_addr_o, vec[v].ea[j]);
            check($sformatf("v%0d_len%0d", v, j), master_len_o, vec[v].el[j]);
            check($sformatf("v%0d_last%0d", v, j), master_last_o, (j == vec[v].n - 1));
            check($sformatf("v%0d_sready%0d", v, j), slave_ready_o, 1);
         end
         @(negedge clk_i);
         check($sformatf("v%0d_idle", v), master_valid_o, 0);
         @(posedge clk_i); #1;
      end

      // Back-pressure: fill the FIFO, hold ID 5, then release and verify order.
      master_ready_i = 1'b0;
      hs_ids.delete();
      fork
         begin
            for (int i = 1; i <= 5; i++) send(mkreq(32'h100 * i, 3, 2, INCR, 0, IDW'(i)));
         end
         begin
            repeat (6) @(negedge clk_i);
            check("full_slave_ready", slave_ready_o, 0);
            check("full_head_id", master_id_o, 1);
            check("full_valid", master_valid_o, 1);
`ifdef AXI_AR_SPLIT_BUFFER_LEVEL_EN
            check("full_level", level_o, DEPTH);
`endif
            repeat (3) @(negedge clk_i);
            check("held_head_id", master_id_o, 1);
            @(posedge clk_i); #1;
            master_ready_i = 1'b1;
         end
      join
      wait_drain(100);
      check("order_count", hs_ids.size(), 5);
      for (int i = 0; i < 5 && i < hs_ids.size(); i++)
         check($sformatf("order_id%0d", i), hs_ids[i], i + 1);

      // Reset during the second sub-burst of a 64-beat request.
      send(mkreq(32'h8000, 63, 3, INCR, 0, 4'hA));
      @(negedge clk_i);
      @(posedge clk_i); #1;
      check("mid_split_addr", master_addr_o, 32'h8080);
      mon_en = 1'b0;
      rst_ni = 1'b0;
      master_ready_i = 1'b0;
      @(posedge clk_i); #1;
      rst_ni = 1'b1;
      exp_q.delete();
      @(negedge clk_i);
      check("midrst_valid", master_valid_o, 0);
      check("midrst_slave_ready", slave_ready_o, 1);
      check("midrst_last", master_last_o, 0);
`ifdef AXI_AR_SPLIT_BUFFER_LEVEL_EN
      check("midrst_level", level_o, 0);
`endif
      @(posedge clk_i); #1;
      mon_en = 1'b1;
      master_ready_i = 1'b1;
      send(mkreq(32'h9000, 7, 2, INCR, 0, 4'hB));
      @(negedge clk_i);
      check("post_rst_valid", master_valid_o, 1);
      check("post_rst_addr", master_addr_o, 32'h9000);
      check("post_rst_len", master_len_o, 7);
      check("post_rst_last", master_last_o, 1);
      @(negedge clk_i);
      check("post_rst_idle", master_valid_o, 0);
      @(posedge clk_i); #1;

      // Randomized traffic with random back-pressure, scored by the monitor.
      rnd_done = 1'b0;
      fork
         begin
            for (int n = 0; n < 40; n++) begin
               repeat ($urandom_range(0, 2)) @(posedge clk_i);
               #1;
               send(mkreq($urandom, 8'($urandom_range(0, 255)), 3'($urandom_range(0, 7)),
                          2'($urandom_range(0, 2)), ($urandom_range(0, 3) == 0), IDW'($urandom)));
            end
            rnd_done = 1'b1;
         end
         begin
            while (!rnd_done) begin
               @(posedge clk_i); #1;
               master_ready_i = ($urandom_range(0, 3) != 0);
            end
         end
      join
      master_ready_i = 1'b1;
      wait_drain(3000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
